pwm_update_ctrl: RTL and testbench
==================================

# pwm_update_ctrl

Register-bank and update sequencer that sits between the I2C register file and `pwm_core`. It holds a staging copy of every PWM configuration word and a live active copy that drives the core. Staged values are committed atomically on the core's counter update event, or immediately on request, so software never produces a torn period or duty cycle.

## Interface
- `WIDTH`, 16, counter/compare word width; the DTG and CFG registers are fixed at 16 bits.
- `clk_psc_i` in 1: core clock, the same clock that drives `pwm_core`.
- `rst_i` in 1: **synchronous, active-high** reset.
- `wr_en_i` in 1: write strobe from the register file, single cycle.
- `addr_i` in 4: register address, used for both read and write.
- `wdata_i` in 16: write data.
- `rd_en_i` in 1: read strobe.
- `rdata_o` out 16: read data.
- `rdata_valid_o` out 1: one-cycle pulse qualifying `rdata_o`.
- `wr_err_o` out 1: one-cycle pulse when a write is rejected.
- `upd_evt_i` in 1: counter overflow/update strobe exported by `pwm_core`.
- `cnt_en_o` out 1: counter enable to the core.
- `psc_o`, `arr_o` out WIDTH: prescaler and auto-reload values.
- `cmp_ch1_start_o`, `cmp_ch1_end_o`, `cmp_ch2_start_o`, `cmp_ch2_end_o` out WIDTH: compare values.
- `dtg_ch1_o`, `dtg_ch2_o` out 8: dead-time values.
- `cfg_ch1_o`, `cfg_ch2_o` out 16: channel configuration words.

## Operation
- Register map:
  - 0x0 CTRL: bit0 CEN (live, not staged), bit1 COMMIT (write-only, self-clearing), bit2 FORCE (write-only, self-clearing).
  - 0x1 PSC, 0x2 ARR, 0x3 CH1_START, 0x4 CH1_END, 0x5 CH2_START, 0x6 CH2_END.
  - 0x7 DTG: [7:0] ch1, [15:8] ch2.
  - 0x8 CFG_CH1, 0x9 CFG_CH2.
  - 0xA STATUS: bit0 ARMED (RO), bit1 ERR (sticky, W1C), bit2 DONE (sticky, W1C).
  - 0xB–0xF reserved.
- Writes to 0x1–0x9 update the staging bank. Reads of 0x1–0x9 return the staging value.
- FSM has states IDLE and ARMED. The two-state register is reset to IDLE.
  - IDLE, COMMIT=1 written → ARMED.
  - ARMED, `upd_evt_i`=1 → copy staging to active; set DONE; → IDLE.
  - ARMED, live CEN=0 → copy staging to active on the next edge; set DONE; → IDLE. No update event would ever arrive, so the commit cannot wait for one.
  - Any state, FORCE=1 written → copy staging to active on the next edge; set DONE; → IDLE. FORCE cancels a pending arm.
- Rejected writes. Each pulses `wr_err_o`, sets ERR, and leaves all state unchanged:
  - a write to 0x1–0x9 while ARMED;
  - a write to a reserved address.
- COMMIT written while already ARMED: no-op, not an error.
- COMMIT and FORCE both set in one write: FORCE wins, and the FSM ends in IDLE.
- Reserved addresses read 0.
- All arithmetic is plain storage: no saturation and no width conversion beyond slicing DTG.

## Timing
- Reset values:
  - `cnt_en_o`=0;
  - ARR (staging and active)=16'hFFFF;
  - every other staging and active word=0;
  - STATUS=0;
  - `rdata_o`=0, `rdata_valid_o`=0, `wr_err_o`=0.
- Write: a register accepted at edge N is visible at N+1. CEN drives `cnt_en_o` directly from edge N+1.
- Read: `rdata_o`/`rdata_valid_o` are valid in the cycle after `rd_en_i`. `rdata_o` holds its value until the next read.
- A read and a write to the same address in the same cycle returns the old value.
- Commit latency:
  - The active outputs change on the edge that samples `upd_evt_i`=1 while ARMED, so the core sees the new values for the next period.
  - FORCE and the CEN=0 auto-commit take one cycle.
- COMMIT write and `upd_evt_i` in the same cycle while IDLE: the event is ignored. The FSM arms and waits for the following event.
- A write to CTRL that sets CEN=0 in the same cycle as COMMIT: the FSM arms at N+1 and auto-commits at N+2.
- `upd_evt_i` while IDLE: no effect.
- Reset asserted mid-ARMED: the pending commit is discarded, and all registers return to their reset values on that edge.

## Structure
- `pwm_ctrl_pkg` holds:
  - the address constants;
  - the CTRL and STATUS bit positions;
  - the reset values (ARR_RST=16'hFFFF);
  - the FSM state enum.
- One sub-module, `pwm_shadow_bank`, stores nine staging/active word pairs. It has a staging write port and a single `commit` input that copies all nine words to the active bank. The FSM and register decode stay in `pwm_update_ctrl`.

## Test plan
- Reset, then read all registers → ARR=16'hFFFF, all else 0, `cnt_en_o`=0.
- Write ARR=99 and CH1_END=50, set CEN=1, then COMMIT; pulse `upd_evt_i` 10 cycles later → `arr_o`/`cmp_ch1_end_o` stay at their old values until the edge sampling the event, then read 99/50; DONE=1; ARMED=0.
- While ARMED, write PSC=7 → `wr_err_o` pulses; ERR=1; the staging PSC is unchanged; the next commit does not carry 7.
- CEN=0 with ARR=200 staged, then COMMIT → `arr_o`=200 two cycles after the COMMIT write, with no `upd_evt_i` needed.
- COMMIT and `upd_evt_i` in the same cycle → no update; the second `upd_evt_i` applies it. FORCE while ARMED → immediate copy and FSM IDLE.
- Write 0xC → `wr_err_o` pulses; a read of 0xC returns 0. Assert reset while ARMED → all outputs return to their reset values and ARMED=0.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared constants and types for the PWM update controller: register map,
// CTRL/STATUS bit positions, reset values and the commit FSM state.
package pwm_ctrl_pkg;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned REG_W     = 16;
    localparam int unsigned DTG_W     = 8;
    localparam int unsigned BANK_SIZE = 9;

    localparam logic [ADDR_W-1:0] ADDR_CTRL      = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_PSC       = 4'h1;
    localparam logic [ADDR_W-1:0] ADDR_ARR       = 4'h2;
    localparam logic [ADDR_W-1:0] ADDR_CH1_START = 4'h3;
    localparam logic [ADDR_W-1:0] ADDR_CH1_END   = 4'h4;
    localparam logic [ADDR_W-1:0] ADDR_CH2_START = 4'h5;
    localparam logic [ADDR_W-1:0] ADDR_CH2_END   = 4'h6;
    localparam logic [ADDR_W-1:0] ADDR_DTG       = 4'h7;
    localparam logic [ADDR_W-1:0] ADDR_CFG_CH1   = 4'h8;
    localparam logic [ADDR_W-1:0] ADDR_CFG_CH2   = 4'h9;
    localparam logic [ADDR_W-1:0] ADDR_STATUS    = 4'hA;

    localparam int unsigned CTRL_CEN_BIT    = 0;
    localparam int unsigned CTRL_COMMIT_BIT = 1;
    localparam int unsigned CTRL_FORCE_BIT  = 2;

    localparam int unsigned STAT_ARMED_BIT = 0;
    localparam int unsigned STAT_ERR_BIT   = 1;
    localparam int unsigned STAT_DONE_BIT  = 2;

    localparam logic [REG_W-1:0] ARR_RST  = 16'hFFFF;
    localparam logic [REG_W-1:0] WORD_RST = 16'h0000;

    // Bank word i holds register address i+1 (PSC at index 0 .. CFG_CH2 at 8).
    typedef logic [BANK_SIZE-1:0][REG_W-1:0] bank_words_t;

    localparam bank_words_t BANK_RST = bank_words_t'({{7{WORD_RST}}, ARR_RST, WORD_RST});

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } upd_state_e;

    function automatic logic is_bank_addr(input logic [ADDR_W-1:0] addr);
        return (addr >= ADDR_PSC) && (addr <= ADDR_CFG_CH2);
    endfunction

    function automatic logic is_reserved_addr(input logic [ADDR_W-1:0] addr);
        return addr > ADDR_STATUS;
    endfunction

endpackage

// File: rtl/pwm_shadow_bank.sv
// Staging/active word pairs for the PWM configuration.
//   wr_en/wr_idx/wr_data : staging write port (index 0..8)
//   commit               : copy every staging word into the active bank
//   staging/active       : full register contents of both banks
module pwm_shadow_bank
    import pwm_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [REG_W-1:0]  wr_data,
    input  logic              commit,
    output bank_words_t       staging,
    output bank_words_t       active
);

    // Commit samples the pre-write staging contents, so a same-edge write
    // lands in staging only.
    always_ff @(posedge clk) begin
        if (rst) begin
            staging <= BANK_RST;
            active  <= BANK_RST;
        end else begin
            if (commit) begin
                active <= staging;
            end
            if (wr_en) begin
                staging[wr_idx] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/pwm_update_ctrl.sv
// Register decode and atomic update sequencer in front of pwm_core.
//   clk_psc_i, rst_i            : core clock, synchronous active-high reset
//   wr_en_i/addr_i/wdata_i      : register write port
//   rd_en_i/rdata_o/rdata_valid_o : register read port (one-cycle latency)
//   wr_err_o                    : pulse on a rejected write
//   upd_evt_i                   : counter update event from the core
//   cnt_en_o, psc_o .. cfg_ch2_o : live configuration driving the core
module pwm_update_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic              clk_psc_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [REG_W-1:0]  wdata_i,
    input  logic              rd_en_i,
    output logic [REG_W-1:0]  rdata_o,
    output logic              rdata_valid_o,
    output logic              wr_err_o,
    input  logic              upd_evt_i,
    output logic              cnt_en_o,
    output logic [WIDTH-1:0]  psc_o,
    output logic [WIDTH-1:0]  arr_o,
    output logic [WIDTH-1:0]  cmp_ch1_start_o,
    output logic [WIDTH-1:0]  cmp_ch1_end_o,
    output logic [WIDTH-1:0]  cmp_ch2_start_o,
    output logic [WIDTH-1:0]  cmp_ch2_end_o,
    output logic [DTG_W-1:0]  dtg_ch1_o,
    output logic [DTG_W-1:0]  dtg_ch2_o,
    output logic [REG_W-1:0]  cfg_ch1_o,
    output logic [REG_W-1:0]  cfg_ch2_o
);

    upd_state_e  state;
    logic        cen;
    logic        err;
    logic        done;
    bank_words_t staging;
    bank_words_t active;

    logic              ctrl_wr_c;
    logic              stat_wr_c;
    logic              bank_wr_c;
    logic              reject_c;
    logic              force_c;
    logic              arm_c;
    logic              commit_c;
    logic [ADDR_W-1:0] bank_idx_c;
    logic [REG_W-1:0]  rd_mux_c;

    // Write decode, commit request and read mux.
    always_comb begin
        ctrl_wr_c  = 1'b0;
        stat_wr_c  = 1'b0;
        bank_wr_c  = 1'b0;
        reject_c   = 1'b0;
        force_c    = 1'b0;
        arm_c      = 1'b0;
        commit_c   = 1'b0;
        bank_idx_c = ADDR_W'(addr_i - ADDR_PSC);
        rd_mux_c   = WORD_RST;

        ctrl_wr_c = wr_en_i && (addr_i == ADDR_CTRL);
        stat_wr_c = wr_en_i && (addr_i == ADDR_STATUS);
        force_c   = ctrl_wr_c && wdata_i[CTRL_FORCE_BIT];
        arm_c     = ctrl_wr_c && wdata_i[CTRL_COMMIT_BIT] && (state == ST_IDLE);
        bank_wr_c = wr_en_i && is_bank_addr(addr_i) && (state == ST_IDLE);
        reject_c  = wr_en_i && ((is_bank_addr(addr_i) && (state == ST_ARMED))
                               || is_reserved_addr(addr_i));
        // A stopped counter never produces an update event, so commit at once.
        commit_c  = force_c || ((state == ST_ARMED) && (upd_evt_i || !cen));

        if (addr_i == ADDR_CTRL) begin
            rd_mux_c[CTRL_CEN_BIT] = cen;
        end else if (addr_i == ADDR_STATUS) begin
            rd_mux_c[STAT_ARMED_BIT] = (state == ST_ARMED);
            rd_mux_c[STAT_ERR_BIT]   = err;
            rd_mux_c[STAT_DONE_BIT]  = done;
        end else if (is_bank_addr(addr_i)) begin
            rd_mux_c = staging[bank_idx_c];
        end
    end

    // Commit FSM, control/status registers and read/error pulses.
    always_ff @(posedge clk_psc_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            cen           <= 1'b0;
            err           <= 1'b0;
            done          <= 1'b0;
            rdata_o       <= WORD_RST;
            rdata_valid_o <= 1'b0;
            wr_err_o      <= 1'b0;
        end else begin
            if (commit_c) begin
                state <= ST_IDLE;
            end else if (arm_c) begin
                state <= ST_ARMED;
            end

            if (ctrl_wr_c) begin
                cen <= wdata_i[CTRL_CEN_BIT];
            end

            if (reject_c) begin
                err <= 1'b1;
            end else if (stat_wr_c && wdata_i[STAT_ERR_BIT]) begin
                err <= 1'b0;
            end

            // A fresh commit outranks a simultaneous W1C of DONE.
            if (commit_c) begin
                done <= 1'b1;
            end else if (stat_wr_c && wdata_i[STAT_DONE_BIT]) begin
                done <= 1'b0;
            end

            wr_err_o      <= reject_c;
            rdata_valid_o <= rd_en_i;
            if (rd_en_i) begin
                rdata_o <= rd_mux_c;
            end
        end
    end

    pwm_shadow_bank u_bank (
        .clk     (clk_psc_i),
        .rst     (rst_i),
        .wr_en   (bank_wr_c),
        .wr_idx  (bank_idx_c),
        .wr_data (wdata_i),
        .commit  (commit_c),
        .staging (staging),
        .active  (active)
    );

    assign cnt_en_o        = cen;
    assign psc_o           = WIDTH'(active[0]);
    assign arr_o           = WIDTH'(active[1]);
    assign cmp_ch1_start_o = WIDTH'(active[2]);
    assign cmp_ch1_end_o   = WIDTH'(active[3]);
    assign cmp_ch2_start_o = WIDTH'(active[4]);
    assign cmp_ch2_end_o   = WIDTH'(active[5]);
    assign dtg_ch1_o       = active[6][DTG_W-1:0];
    assign dtg_ch2_o       = active[6][REG_W-1:DTG_W];
    assign cfg_ch1_o       = active[7];
    assign cfg_ch2_o       = active[8];

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// Randomized and directed bench for pwm_update_ctrl against a register-level
// reference model of staging/active banks and commit rules.
module tb_pwm_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [3:0]  addr_i = 4'h0;
    logic [15:0] wdata_i = 16'h0;
    logic        rd_en_i = 1'b0;
    logic [15:0] rdata_o;
    logic        rdata_valid_o;
    logic        wr_err_o;
    logic        upd_evt_i = 1'b0;
    logic        cnt_en_o;
    logic [15:0] psc_o, arr_o;
    logic [15:0] cmp_ch1_start_o, cmp_ch1_end_o, cmp_ch2_start_o, cmp_ch2_end_o;
    logic [7:0]  dtg_ch1_o, dtg_ch2_o;
    logic [15:0] cfg_ch1_o, cfg_ch2_o;

    always #5 clk = ~clk;

    pwm_update_ctrl #(.WIDTH(16)) dut (
        .clk_psc_i       (clk),
        .rst_i           (rst_i),
        .wr_en_i         (wr_en_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .rd_en_i         (rd_en_i),
        .rdata_o         (rdata_o),
        .rdata_valid_o   (rdata_valid_o),
        .wr_err_o        (wr_err_o),
        .upd_evt_i       (upd_evt_i),
        .cnt_en_o        (cnt_en_o),
        .psc_o           (psc_o),
        .arr_o           (arr_o),
        .cmp_ch1_start_o (cmp_ch1_start_o),
        .cmp_ch1_end_o   (cmp_ch1_end_o),
        .cmp_ch2_start_o (cmp_ch2_start_o),
        .cmp_ch2_end_o   (cmp_ch2_end_o),
        .dtg_ch1_o       (dtg_ch1_o),
        .dtg_ch2_o       (dtg_ch2_o),
        .cfg_ch1_o       (cfg_ch1_o),
        .cfg_ch2_o       (cfg_ch2_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: registers indexed by their bus address.
    logic [15:0] m_stage [1:9];
    logic [15:0] m_act   [1:9];
    bit          m_cen, m_armed, m_err, m_done, m_rv, m_werr;
    logic [15:0] m_rdata;

    function automatic logic [15:0] m_read(input logic [3:0] a);
        if (a == 4'd0)                return {15'h0, m_cen};
        if (a >= 4'd1 && a <= 4'd9)   return m_stage[a];
        if (a == 4'd10)               return {13'h0, m_done, m_err, m_armed};
        return 16'h0;
    endfunction

    task automatic model_step(input bit r, input bit we, input logic [3:0] a,
                              input logic [15:0] d, input bit rd, input bit ev);
        bit frc, cmt, do_copy, rej, bank_w;
        if (r) begin
            for (int i = 1; i <= 9; i++) begin
                m_stage[i] = (i == 2) ? 16'hFFFF : 16'h0;
                m_act[i]   = (i == 2) ? 16'hFFFF : 16'h0;
            end
            m_cen = 0; m_armed = 0; m_err = 0; m_done = 0;
            m_rdata = 16'h0; m_rv = 0; m_werr = 0;
            return;
        end
        if (rd) m_rdata = m_read(a);
        m_rv    = rd;
        frc     = we && (a == 4'd0) && d[2];
        cmt     = we && (a == 4'd0) && d[1];
        do_copy = frc || (m_armed && (ev || !m_cen));
        bank_w  = we && (a >= 4'd1) && (a <= 4'd9);
        rej     = (bank_w && m_armed) || (we && a >= 4'd11);
        if (do_copy)
            for (int i = 1; i <= 9; i++) m_act[i] = m_stage[i];
        if (bank_w && !m_armed) m_stage[a] = d;
        if (we && a == 4'd0) m_cen = d[0];
        if (we && a == 4'd10) begin
            if (d[1]) m_err = 0;
            if (d[2]) m_done = 0;
        end
        if (rej) m_err = 1;
        if (do_copy) m_done = 1;
        m_werr = rej;
        if (do_copy) m_armed = 0;
        else if (cmt) m_armed = 1;
    endtask

    task automatic compare_all();
        check("rdata", rdata_o, m_rdata);
        check("rdata_valid", rdata_valid_o, m_rv);
        check("wr_err", wr_err_o, m_werr);
        check("cnt_en", cnt_en_o, m_cen);
        check("psc", psc_o, m_act[1]);
        check("arr", arr_o, m_act[2]);
        check("ch1_start", cmp_ch1_start_o, m_act[3]);
        check("ch1_end", cmp_ch1_end_o, m_act[4]);
        check("ch2_start", cmp_ch2_start_o, m_act[5]);
        check("ch2_end", cmp_ch2_end_o, m_act[6]);
        check("dtg_ch1", dtg_ch1_o, m_act[7][7:0]);
        check("dtg_ch2", dtg_ch2_o, m_act[7][15:8]);
        check("cfg_ch1", cfg_ch1_o, m_act[8]);
        check("cfg_ch2", cfg_ch2_o, m_act[9]);
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic cyc(input bit r, input bit we, input logic [3:0] a,
                       input logic [15:0] d, input bit rd, input bit ev);
        @(negedge clk);
        rst_i = r; wr_en_i = we; addr_i = a; wdata_i = d; rd_en_i = rd; upd_evt_i = ev;
        model_step(r, we, a, d, rd, ev);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        cyc(0, 1, a, d, 0, 0);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(0, 0, a, 16'h0, 1, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 4'h0, 16'h0, 0, 0);
    endtask

    task automatic evt();
        cyc(0, 0, 4'h0, 16'h0, 0, 1);
    endtask

    initial begin
        bit          r, we, rdv, ev;
        logic [3:0]  a;
        logic [15:0] d;

        // Reset state
        cyc(1, 0, 4'h0, 16'h0, 0, 0);
        cyc(1, 0, 4'h0, 16'h0, 0, 0);
        check("rst_cnt_en", cnt_en_o, 1'b0);
        check("rst_arr_out", arr_o, 16'hFFFF);
        rd(4'h2);  check("rst_arr_rd", rdata_o, 16'hFFFF);
        rd(4'h1);  check("rst_psc_rd", rdata_o, 16'h0);
        rd(4'hA);  check("rst_status_rd", rdata_o, 16'h0);
        for (int i = 0; i < 16; i++) rd(4'(i));

        // Commit on update event
        wr(4'h2, 16'd99);
        wr(4'h4, 16'd50);
        wr(4'h0, 16'h1);
        check("cen_live", cnt_en_o, 1'b1);
        wr(4'h0, 16'h3);
        repeat (9) idle();
        check("arr_hold", arr_o, 16'hFFFF);
        check("ch1_end_hold", cmp_ch1_end_o, 16'h0);
        evt();
        check("arr_commit", arr_o, 16'd99);
        check("ch1_end_commit", cmp_ch1_end_o, 16'd50);
        rd(4'hA);  check("status_done", rdata_o, 16'h4);

        // Write while armed is rejected
        wr(4'h0, 16'h3);
        wr(4'h1, 16'd7);
        check("armed_wr_err", wr_err_o, 1'b1);
        rd(4'hA);  check("status_armed_err", rdata_o, 16'h7);
        rd(4'h1);  check("psc_staged_kept", rdata_o, 16'h0);
        evt();
        check("psc_not_7", psc_o, 16'h0);
        wr(4'hA, 16'h6);
        rd(4'hA);  check("status_w1c", rdata_o, 16'h0);

        // CEN=0 auto-commit
        wr(4'h0, 16'h0);
        wr(4'h2, 16'd200);
        wr(4'h0, 16'h2);
        check("arr_cen0_first", arr_o, 16'd99);
        idle();
        check("arr_cen0_second", arr_o, 16'd200);

        // COMMIT with event in same cycle, then FORCE while armed
        wr(4'h0, 16'h1);
        wr(4'h2, 16'd300);
        cyc(0, 1, 4'h0, 16'h3, 0, 1);
        check("arr_same_cycle_evt", arr_o, 16'd200);
        idle();
        check("arr_wait_evt", arr_o, 16'd200);
        evt();
        check("arr_second_evt", arr_o, 16'd300);
        wr(4'h2, 16'd400);
        wr(4'h0, 16'h3);
        wr(4'h0, 16'h5);
        check("arr_force", arr_o, 16'd400);
        rd(4'hA);  check("status_after_force", rdata_o, 16'h4);

        // Reserved address
        wr(4'hC, 16'h1234);
        check("reserved_wr_err", wr_err_o, 1'b1);
        rd(4'hC);  check("reserved_rd", rdata_o, 16'h0);

        // Reset while armed
        wr(4'h2, 16'd500);
        wr(4'h0, 16'h3);
        cyc(1, 0, 4'h0, 16'h0, 0, 0);
        check("rst_armed_arr", arr_o, 16'hFFFF);
        check("rst_armed_cen", cnt_en_o, 1'b0);
        rd(4'hA);  check("rst_armed_status", rdata_o, 16'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 399) == 0);
            we  = ($urandom_range(0, 2) == 0);
            rdv = ($urandom_range(0, 2) == 0);
            ev  = ($urandom_range(0, 7) == 0);
            a   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15))
                                              : 4'($urandom_range(0, 10));
            d   = 16'($urandom);
            if (a == 4'h0)
                d = {13'h0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 7) != 0)};
            cyc(r, we, a, d, rdv, ev);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
